// File: rtl/iob_demux_router.sv
// rtl/iob_demux_router.sv - header-routed packet demux front end with one registered output word
module iob_demux_router #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int SEL_W  = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic [DATA_W-1:0] data_o,
    output logic [N-1:0]      m_valid_o,
    input  logic [N-1:0]      m_ready_i,
    output logic              m_last_o,
    output logic              err_o,
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             out_valid;
    logic             out_empty;
    logic             s_acc;
    logic             hdr_legal;
    logic [SEL_W-1:0] dest;

    assign dest      = s_data_i[SEL_W-1:0];
    // Extra MSB keeps the compare meaningful when N is a power of two.
    assign hdr_legal = ({1'b0, dest} < (SEL_W + 1)'(N));

    // The output slot is free if empty or its word leaves on this edge.
    assign out_empty = !out_valid || m_ready_i[sel_o];
    assign s_ready_o = !rst_i && ((state == DROP) || out_empty);
    assign s_acc     = s_valid_i && s_ready_o;
    assign m_valid_o = out_valid ? ({{(N-1){1'b0}}, 1'b1} << sel_o) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s_acc && !s_last_i) begin
                    state_nxt = hdr_legal ? PAYLOAD : DROP;
                end
            end
            PAYLOAD, DROP: begin
                if (s_acc && s_last_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_o      <= '0;
            data_o     <= '0;
            m_last_o   <= 1'b0;
            out_valid  <= 1'b0;
            err_o      <= 1'b0;
            pkt_cnt_o  <= 16'd0;
            drop_cnt_o <= 16'd0;
        end else begin
            err_o <= 1'b0;
            if (out_valid && m_ready_i[sel_o]) begin
                out_valid <= 1'b0;
            end
            if (s_acc) begin
                case (state)
                    IDLE: begin
                        // Header words only steer; they never reach data_o.
                        if (hdr_legal) begin
                            sel_o     <= dest;
                            pkt_cnt_o <= pkt_cnt_o + 16'd1;
                        end else begin
                            err_o      <= 1'b1;
                            drop_cnt_o <= drop_cnt_o + 16'd1;
                        end
                    end
                    PAYLOAD: begin
                        data_o    <= s_data_i;
                        m_last_o  <= s_last_i;
                        out_valid <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/iob_demux_router.md
IOB_DEMUX_ROUTER -- requirements
Module: iob_demux_router

Interface
REQ-001 Parameter: DATA_W, default 32, width of stream words and of data_o.
REQ-002 Parameter: N, default 4, number of destinations; legal range 2..256.
REQ-003 Parameter: SEL_W, default $clog2(N), selector width; derived, never overridden.
REQ-004 Port: clk_i  input  1  single clock; all logic on rising edge.
REQ-005 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-006 Port: s_valid_i  input  1  upstream word valid.
REQ-007 Port: s_data_i  input  DATA_W  upstream word; first word of a packet is the header.
REQ-008 Port: s_last_i  input  1  marks final word of a packet.
REQ-009 Port: s_ready_o  output  1  router accepts the upstream word this cycle.
REQ-010 Port: sel_o  output  SEL_W  destination index; drives the demux selector.
REQ-011 Port: data_o  output  DATA_W  registered payload word; drives the demux data input.
REQ-012 Port: m_valid_o  output  N  one-hot valid; bit sel_o set when data_o is valid.
REQ-013 Port: m_ready_i  input  N  per-destination ready.
REQ-014 Port: m_last_o  output  1  registered copy of s_last_i for the word in data_o.
REQ-015 Port: err_o  output  1  one-cycle pulse on an illegal destination header.
REQ-016 Port: pkt_cnt_o  output  16  count of headers accepted with legal destination.
REQ-017 Port: drop_cnt_o  output  16  count of packets dropped.

Function
REQ-018 Word transfer upstream SHALL occur when s_valid_i and s_ready_o are both 1; downstream when m_valid_o[sel_o] and m_ready_i[sel_o] are both 1.
REQ-019 FSM states SHALL be IDLE, PAYLOAD, DROP.
REQ-020 IDLE: s_ready_o = out_empty, where out_empty = no valid word or current word transferring this cycle.
REQ-021 IDLE header accept: dest = s_data_i[SEL_W-1:0]; dest < N -> sel_o <= dest, pkt_cnt_o += 1, next PAYLOAD; dest >= N -> err_o pulse, drop_cnt_o += 1, next DROP.
REQ-022 Header word SHALL never be forwarded to data_o.
REQ-023 Header with s_last_i=1 (zero-length packet): counters update as REQ-021, next state IDLE, no downstream word.
REQ-024 PAYLOAD: s_ready_o = out_empty; accepted word SHALL load data_o/m_last_o and assert m_valid_o[sel_o] next cycle (latency 1 cycle, throughput 1 word/cycle).
REQ-025 PAYLOAD: accepting word with s_last_i=1 -> next IDLE.
REQ-026 DROP: s_ready_o = 1; words discarded; word with s_last_i=1 -> next IDLE.
REQ-027 sel_o, data_o, m_last_o SHALL remain stable while m_valid_o is nonzero and m_ready_i[sel_o] is 0.
REQ-028 m_valid_o SHALL be zero or one-hot at all times; m_ready_i bits other than sel_o SHALL be ignored.
REQ-029 sel_o SHALL change only on legal header accept; a pending output word blocks header acceptance (REQ-020).
REQ-030 pkt_cnt_o, drop_cnt_o SHALL wrap 0xFFFF -> 0x0000 silently.
REQ-031 When N is not a power of two, header values N..2^SEL_W-1 are illegal; when N is a power of two no header is illegal.

Reset
REQ-032 rst_i high at a rising edge SHALL force: state IDLE, sel_o 0, data_o 0, m_valid_o 0, m_last_o 0, err_o 0, pkt_cnt_o 0, drop_cnt_o 0.
REQ-033 While rst_i is high, s_ready_o SHALL be 0.
REQ-034 Reset mid-packet SHALL discard the pending output word and partial packet; after release the next accepted word is a header.

Verification
REQ-035 N=4: header 0x2, payload 0xA, 0xB(last), m_ready_i=4'hF -> m_valid_o=4'b0100 one cycle after each payload accept, data 0xA then 0xB, m_last_o on 0xB, pkt_cnt_o=1.
REQ-036 N=3: header 0x3 then 2 words (last on 2nd) -> err_o one pulse, no m_valid_o, drop_cnt_o=1, s_ready_o=1 throughout, back to IDLE.
REQ-037 Backpressure: m_ready_i[1]=0 for 5 cycles mid-packet to dest 1 -> data_o, sel_o stable, s_ready_o=0, no word lost or duplicated after release.
REQ-038 Back-to-back packets dest 3 then dest 0 while dest 3 stalls on last word -> header for dest 0 not accepted until dest 3 last word transfers; sel_o changes 3->0 only then.
REQ-039 Header 0x1 with s_last_i=1 -> pkt_cnt_o increments, no m_valid_o, state IDLE next cycle.
REQ-040 Assert rst_i during PAYLOAD with a pending word -> next cycle all outputs at reset values; 0xFFFF+1 packets afterward -> pkt_cnt_o wraps to 0.
